priority_controller: RTL and testbench
======================================

# priority_controller

Arbiter stage directly upstream of the execute-stage priority mux. Each cycle it picks one of the nine execution units presenting a completed result and drives the mux select (`priority_t`). It stalls every unit that was not accepted and keeps the grant stable while writeback is back-pressured. An optional aging scheme stops low-priority units from starving behind long-latency floating-point traffic.

## Interface
Parameters:
- `NUM_UNITS`, default 9: number of arbitrated units. Fixed by the package enum.
- `AGE_W`, default 4: width of each per-unit wait counter.
- `AGE_LIMIT`, default 8: wait count at which a unit is considered starved. Must be less than 2^AGE_W.

Ports:
- `clk` in 1: core clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `unit_valid_i` in 9: unit n holds a valid result. Bit index is `unit_idx_e`.
- `wb_stall_i` in 1: EXE/MEM register cannot accept this cycle.
- `flush_i` in 1: pipeline flush from the hazard unit.
- `p_sel_o` out `priority_t`: select for the priority mux.
- `grant_valid_o` out 1: a unit is being accepted this cycle.
- `unit_stall_o` out 9: hold request to each unit; the unit keeps its result and pipeline bus.

## Operation
- **Fixed priority**, highest first: FDIV, FSQRT, R4, FMUL, FADD_SUB, DIV, MUL, FP, ALU. This matches the `unit_idx_e` order, with bit 0 highest.
- **Candidate selection** (combinational, same cycle):
  - If any unit is starved, select the highest-priority starved unit.
  - Otherwise select the highest-priority valid unit.
  - If no unit is valid, `p_sel_o = DEFAULT_unit` and `grant_valid_o = 0`.
- **Accept:**
  - With `wb_stall_i = 0`, the candidate is accepted.
  - `unit_stall_o[n] = unit_valid_i[n] & ~granted[n]`.
- **Back-pressure:** with `wb_stall_i = 1`:
  - `unit_stall_o = unit_valid_i`.
  - `p_sel_o` still shows the current selection.
  - `grant_valid_o = 0`.
- **FSM** (2 states, reset to IDLE):
  - IDLE:
    - On a valid candidate with `wb_stall_i`, latch the candidate into `lock_q` and go to LOCKED.
    - Otherwise stay in IDLE.
  - LOCKED:
    - `p_sel_o` is taken from `lock_q` regardless of new higher-priority arrivals. There is no preemption under stall.
    - On `~wb_stall_i`, the locked unit is granted and the FSM returns to IDLE in the same cycle.
    - If the locked unit's valid drops (protocol error), return to IDLE and raise the assertion.
- **Aging counters:**
  - Each counter increments while its unit is valid, not granted, and `wb_stall_i = 0`.
  - Each counter clears on grant.
  - Counters saturate at 2^AGE_W − 1.
  - A unit is starved when its count is at least `AGE_LIMIT`.
- **Flush** (highest precedence over stall and grant):
  - FSM goes to IDLE; `lock_q` and all counters clear.
  - That cycle: `p_sel_o = DEFAULT_unit`, `grant_valid_o = 0`, `unit_stall_o = 0`.

## Timing
- Select, stall and grant are combinational from `unit_valid_i`, `wb_stall_i`, `flush_i` and the registered state. The select is zero-cycle: a result valid in cycle t is muxed in cycle t if granted.
- The FSM, `lock_q` and counters update on the rising edge of `clk`.
- While `reset_n = 0`, outputs are forced:
  - `p_sel_o = DEFAULT_unit`
  - `grant_valid_o = 0`
  - `unit_stall_o = 0`
- Reset asserted mid-LOCKED drops the lock immediately. After release the FSM starts in IDLE.
- Simultaneous arrivals: exactly one grant per cycle. All other valid units are stalled and age by 1.
- Maximum wait with aging enabled and a single starved contender: `AGE_LIMIT` + 1 accepting cycles.

## Configuration
- Macro: `PRIORITY_AGING_EN`.
- **Defined:** the counters and starvation override are built as described above.
- **Undefined:**
  - Counters are removed and the starved vector is tied to 0.
  - Arbitration is pure fixed priority, so ALU can starve indefinitely.
  - `AGE_W` and `AGE_LIMIT` are ignored.

## Structure
- Shared package `riscv_types` holds:
  - `priority_t`, extended only if needed.
  - New `unit_idx_e` mapping bit position to unit.
  - A constant function or table mapping `unit_idx_e` to `priority_t`.
  - Default `AGE_LIMIT`.
- One sub-module, `prio_age_counter`: a single saturating wait counter, instantiated `NUM_UNITS` times under `PRIORITY_AGING_EN`.

## Test plan
- **Contention:** FMUL and ALU valid, no stall. FMUL is granted, `p_sel_o = FMUL_unit`, `unit_stall_o` has only the ALU bit set, `grant_valid_o = 1`.
- **Stall lock:**
  - Cycle t: ALU valid with `wb_stall_i = 1`.
  - Cycle t+1: FDIV becomes valid, stall still high. `p_sel_o` stays `ALU_unit`.
  - Cycle t+2: stall drops. ALU is granted and FDIV is stalled.
- **Idle:** `unit_valid_i = 0`. `p_sel_o = DEFAULT_unit`, `grant_valid_o = 0`, `unit_stall_o = 0`.
- **Aging** (`AGE_LIMIT = 8`, macro defined): FDIV and ALU valid continuously. ALU is granted on accepting cycle 9. With the macro undefined, ALU is never granted.
- **Flush:** flush while LOCKED. Same cycle `p_sel_o = DEFAULT_unit` and stalls are 0. Next cycle the FSM is IDLE with counters at 0.
- **Reset mid-operation:** `reset_n` low while LOCKED with DIV pending. Outputs are at reset values immediately. After release with only DIV valid, DIV is granted in the first cycle.

Source files
------------

// File: rtl/riscv_types.sv
// Shared core types: priority-mux select, execution-unit index order,
// arbiter FSM state and the unit-index to mux-select mapping.
package riscv_types;

    localparam int NUM_UNITS_C       = 9;
    localparam int AGE_W_DEFAULT     = 4;
    localparam int AGE_LIMIT_DEFAULT = 8;

    typedef enum logic [3:0] {
        DEFAULT_unit  = 4'd0,
        ALU_unit      = 4'd1,
        FP_unit       = 4'd2,
        MUL_unit      = 4'd3,
        DIV_unit      = 4'd4,
        FADD_SUB_unit = 4'd5,
        FMUL_unit     = 4'd6,
        R4_unit       = 4'd7,
        FSQRT_unit    = 4'd8,
        FDIV_unit     = 4'd9
    } priority_t;

    // Bit position in the unit vectors; bit 0 is the highest priority.
    typedef enum logic [3:0] {
        IDX_FDIV     = 4'd0,
        IDX_FSQRT    = 4'd1,
        IDX_R4       = 4'd2,
        IDX_FMUL     = 4'd3,
        IDX_FADD_SUB = 4'd4,
        IDX_DIV      = 4'd5,
        IDX_MUL      = 4'd6,
        IDX_FP       = 4'd7,
        IDX_ALU      = 4'd8
    } unit_idx_e;

    typedef enum logic {
        PC_IDLE   = 1'b0,
        PC_LOCKED = 1'b1
    } pc_state_e;

    function automatic priority_t unit_to_prio(input unit_idx_e idx);
        priority_t p;
        case (idx)
            IDX_FDIV:     p = FDIV_unit;
            IDX_FSQRT:    p = FSQRT_unit;
            IDX_R4:       p = R4_unit;
            IDX_FMUL:     p = FMUL_unit;
            IDX_FADD_SUB: p = FADD_SUB_unit;
            IDX_DIV:      p = DIV_unit;
            IDX_MUL:      p = MUL_unit;
            IDX_FP:       p = FP_unit;
            IDX_ALU:      p = ALU_unit;
            default:      p = DEFAULT_unit;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/prio_age_counter.sv
// Saturating wait counter for one arbitrated unit.
// Ports: clk, reset_n (async low), clr_i, inc_i, starved_o (count >= AGE_LIMIT).
module prio_age_counter
    import riscv_types::*;
#(
    parameter int AGE_W     = AGE_W_DEFAULT,
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic starved_o
);

    localparam logic [AGE_W-1:0] SAT_C   = '1;
    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] cnt_q;
    logic [AGE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SAT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/priority_controller.sv
// Execute-stage result arbiter: picks one of nine units for the priority mux,
// stalls the rest and holds the grant stable under writeback back-pressure.
// Ports: clk, reset_n (async low), unit_valid_i, wb_stall_i, flush_i,
//        p_sel_o, grant_valid_o, unit_stall_o.
// Build option: define PRIORITY_AGING_EN to add per-unit starvation aging.
module priority_controller
    import riscv_types::*;
#(
    parameter int NUM_UNITS = NUM_UNITS_C,
    parameter int AGE_W     = AGE_W_DEFAULT,
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_UNITS-1:0] unit_valid_i,
    input  logic                 wb_stall_i,
    input  logic                 flush_i,
    output priority_t            p_sel_o,
    output logic                 grant_valid_o,
    output logic [NUM_UNITS-1:0] unit_stall_o
);

    if (AGE_LIMIT >= (1 << AGE_W)) begin : g_bad_age_cfg
        $error("AGE_LIMIT must be below 2**AGE_W");
    end

    pc_state_e state_q, state_d;
    unit_idx_e lock_q, lock_d;

    logic [NUM_UNITS-1:0] starved;
    logic [NUM_UNITS-1:0] pick_vec;
    logic [NUM_UNITS-1:0] granted;
    unit_idx_e            cand_idx;
    unit_idx_e            sel_idx;
    logic                 cand_valid;
    logic                 lock_hold;
    logic                 sel_valid;
    logic                 grant;

`ifdef PRIORITY_AGING_EN
    logic [NUM_UNITS-1:0] age_starved;
    logic [NUM_UNITS-1:0] age_inc;
    logic [NUM_UNITS-1:0] age_clr;

    // No aging while back-pressured: nobody loses a slot that cycle.
    assign age_inc = unit_valid_i & ~granted
                   & {NUM_UNITS{~wb_stall_i & ~flush_i}};
    assign age_clr = granted | {NUM_UNITS{flush_i}};

    for (genvar n = 0; n < NUM_UNITS; n++) begin : g_age
        prio_age_counter #(
            .AGE_W     (AGE_W),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr_i     (age_clr[n]),
            .inc_i     (age_inc[n]),
            .starved_o (age_starved[n])
        );
    end

    // A stale count on an idle unit must not win the override.
    assign starved = age_starved & unit_valid_i;
`else
    assign starved = '0;
`endif

    // Lowest set index wins, so scan downward and let later hits overwrite.
    always_comb begin
        pick_vec   = (|starved) ? starved : unit_valid_i;
        cand_valid = |unit_valid_i;
        cand_idx   = IDX_FDIV;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                cand_idx = unit_idx_e'(i[3:0]);
            end
        end
    end

    assign lock_hold = (state_q == PC_LOCKED) && unit_valid_i[lock_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PC_IDLE;
            lock_q  <= IDX_FDIV;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (flush_i) begin
            state_d = PC_IDLE;
            lock_d  = IDX_FDIV;
        end else begin
            unique case (state_q)
                PC_IDLE: begin
                    if (cand_valid && wb_stall_i) begin
                        state_d = PC_LOCKED;
                        lock_d  = cand_idx;
                    end
                end
                PC_LOCKED: begin
                    // Leave on accept, or when the locked unit vanished.
                    if (!lock_hold || !wb_stall_i) begin
                        state_d = PC_IDLE;
                    end
                end
                default: state_d = PC_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_idx      = lock_hold ? lock_q : cand_idx;
        sel_valid    = lock_hold | cand_valid;
        p_sel_o      = DEFAULT_unit;
        grant        = 1'b0;
        granted      = '0;
        unit_stall_o = '0;
        if (reset_n && !flush_i) begin
            if (sel_valid) begin
                p_sel_o = unit_to_prio(sel_idx);
            end
            grant = sel_valid & ~wb_stall_i;
            if (grant) begin
                granted[sel_idx] = 1'b1;
            end
            unit_stall_o = unit_valid_i & ~granted;
        end
    end

    assign grant_valid_o = grant;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && !flush_i && (state_q == PC_LOCKED)) begin
            assert (unit_valid_i[lock_q])
            else $error("locked unit dropped valid before grant");
        end
    end
`endif

endmodule

// File: tb/tb_priority_controller.sv
// Bench for priority_controller: directed scenarios plus random traffic
// against a cycle-level arbitration model.
module tb_priority_controller;
    import riscv_types::*;

    localparam logic [8:0] B_FDIV = 9'h001;
    localparam logic [8:0] B_FMUL = 9'h008;
    localparam logic [8:0] B_DIV  = 9'h020;
    localparam logic [8:0] B_ALU  = 9'h100;
    localparam int LIMIT = 8;
    localparam int SAT   = 15;
`ifdef PRIORITY_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] valid;
    logic       stall;
    logic       flush;
    priority_t  p_sel;
    logic       gv;
    logic [8:0] ustall;

    always #5 clk = ~clk;

    priority_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .unit_valid_i  (valid),
        .wb_stall_i    (stall),
        .flush_i       (flush),
        .p_sel_o       (p_sel),
        .grant_valid_o (gv),
        .unit_stall_o  (ustall)
    );

    int total = 0;
    int bad   = 0;

    priority_t name_of [9];
    int        wcnt [9];
    bit        m_locked;
    int        m_lock;

    priority_t  e_sel;
    logic       e_gv;
    logic [8:0] e_stall;
    int         e_win;

    task automatic model_eval();
        e_win = -1;
        if (!reset_n || flush) begin
            e_sel   = DEFAULT_unit;
            e_gv    = 1'b0;
            e_stall = '0;
        end else begin
            if (m_locked && valid[m_lock]) begin
                e_win = m_lock;
            end else begin
                if (AGING) begin
                    for (int i = 0; i < 9; i++)
                        if (e_win < 0 && valid[i] && wcnt[i] >= LIMIT) e_win = i;
                end
                for (int i = 0; i < 9; i++)
                    if (e_win < 0 && valid[i]) e_win = i;
            end
            e_sel   = (e_win < 0) ? DEFAULT_unit : name_of[e_win];
            e_gv    = (e_win >= 0) && !stall;
            e_stall = valid;
            if (e_gv) e_stall[e_win] = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (!reset_n || flush) begin
            m_locked = 1'b0;
            for (int i = 0; i < 9; i++) wcnt[i] = 0;
        end else begin
            if (m_locked) begin
                if (!valid[m_lock] || !stall) m_locked = 1'b0;
            end else if (stall && e_win >= 0) begin
                m_locked = 1'b1;
                m_lock   = e_win;
            end
            for (int i = 0; i < 9; i++) begin
                if (e_gv && i == e_win) wcnt[i] = 0;
                else if (valid[i] && !stall && wcnt[i] < SAT) wcnt[i]++;
            end
        end
    endtask

    task automatic check_now(input string tag);
        model_eval();
        total++;
        assert (p_sel === e_sel) else begin
            bad++;
            $error("FAIL %s p_sel got=%0d want=%0d", tag, p_sel, e_sel);
        end
        total++;
        assert (gv === e_gv) else begin
            bad++;
            $error("FAIL %s grant got=%b want=%b", tag, gv, e_gv);
        end
        total++;
        assert (ustall === e_stall) else begin
            bad++;
            $error("FAIL %s stall got=%h want=%h", tag, ustall, e_stall);
        end
    endtask

    task automatic hand(input string tag, input priority_t s,
                        input logic g, input logic [8:0] st);
        total++;
        assert (p_sel === s) else begin
            bad++;
            $error("FAIL %s p_sel got=%0d want=%0d", tag, p_sel, s);
        end
        total++;
        assert (gv === g) else begin
            bad++;
            $error("FAIL %s grant got=%b want=%b", tag, gv, g);
        end
        total++;
        assert (ustall === st) else begin
            bad++;
            $error("FAIL %s stall got=%h want=%h", tag, ustall, st);
        end
    endtask

    task automatic drive(input string tag, input logic [8:0] v,
                         input logic s, input logic f);
        valid = v;
        stall = s;
        flush = f;
        #3;
        check_now(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        int         alu_first;
        logic [8:0] pend;
        logic [8:0] v;
        logic [8:0] arr;
        logic       s;
        logic       f;

        name_of = '{FDIV_unit, FSQRT_unit, R4_unit, FMUL_unit,
                    FADD_SUB_unit, DIV_unit, MUL_unit, FP_unit, ALU_unit};
        for (int i = 0; i < 9; i++) wcnt[i] = 0;
        m_locked = 1'b0;
        m_lock   = 0;

        reset_n = 1'b0;
        drive("reset", B_FMUL | B_ALU, 1'b0, 1'b0);
        hand("reset_hand", DEFAULT_unit, 1'b0, 9'h000);
        tick();
        reset_n = 1'b1;

        drive("contend", B_FMUL | B_ALU, 1'b0, 1'b0);
        hand("contend_hand", FMUL_unit, 1'b1, B_ALU);
        tick();

        drive("idle", 9'h000, 1'b0, 1'b0);
        hand("idle_hand", DEFAULT_unit, 1'b0, 9'h000);
        tick();

        drive("lock_t0", B_ALU, 1'b1, 1'b0);
        hand("lock_t0_hand", ALU_unit, 1'b0, B_ALU);
        tick();
        drive("lock_t1", B_ALU | B_FDIV, 1'b1, 1'b0);
        hand("lock_t1_hand", ALU_unit, 1'b0, B_ALU | B_FDIV);
        tick();
        drive("lock_t2", B_ALU | B_FDIV, 1'b0, 1'b0);
        hand("lock_t2_hand", ALU_unit, 1'b1, B_FDIV);
        tick();

        drive("age_flush", B_FDIV, 1'b0, 1'b1);
        tick();
        alu_first = 0;
        for (int k = 1; k <= 12; k++) begin
            drive("age_step", B_FDIV | B_ALU, 1'b0, 1'b0);
            if (alu_first == 0 && gv === 1'b1 && p_sel === ALU_unit)
                alu_first = k;
            tick();
        end
        total++;
        assert (alu_first === (AGING ? 9 : 0)) else begin
            bad++;
            $error("FAIL age_first got=%0d want=%0d", alu_first,
                   AGING ? 9 : 0);
        end

        drive("fl_lock", B_DIV, 1'b1, 1'b0);
        tick();
        drive("fl_flush", B_DIV | B_FDIV, 1'b1, 1'b1);
        hand("fl_flush_hand", DEFAULT_unit, 1'b0, 9'h000);
        tick();
        drive("fl_after", B_DIV | B_FDIV, 1'b1, 1'b0);
        hand("fl_after_hand", FDIV_unit, 1'b0, B_DIV | B_FDIV);
        tick();
        drive("fl_grant", B_DIV | B_FDIV, 1'b0, 1'b0);
        hand("fl_grant_hand", FDIV_unit, 1'b1, B_DIV);
        tick();

        drive("rst_lock", B_DIV, 1'b1, 1'b0);
        tick();
        valid = B_DIV | B_FDIV;
        stall = 1'b1;
        flush = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_now("rst_mid");
        hand("rst_mid_hand", DEFAULT_unit, 1'b0, 9'h000);
        tick();
        reset_n = 1'b1;
        drive("rst_after", B_DIV, 1'b0, 1'b0);
        hand("rst_after_hand", DIV_unit, 1'b1, 9'h000);
        tick();

        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            arr = 9'($urandom & $urandom & 32'h1ff);
            v   = pend | arr;
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 49) == 0);
            drive("rand", v, s, f);
            pend = v;
            if (f) pend = '0;
            else if (e_gv) pend[e_win] = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
